// File: rtl/instruction_loader.sv
// Byte-stream program loader: packs 4 bytes little-endian per word and writes them
// to instruction memory at ascending addresses. Optional Checksum port under LOADER_CHECKSUM_EN.
module instruction_loader #(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned DEPTH_WORDS = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        Start,
  input  logic [15:0] Length,
  input  logic        ByteValid,
  input  logic [7:0]  ByteData,
  output logic        ByteReady,
  output logic        WrEn,
  output logic [31:0] WrAddress,
  output logic [31:0] WrData,
  output logic        Busy,
  output logic        Done,
  output logic        Error,
`ifdef LOADER_CHECKSUM_EN
  output logic [31:0] Checksum,
`endif
  output logic [1:0]  fsm_state
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RECV  = 2'd1;
  localparam logic [1:0] WRITE = 2'd2;
  localparam logic [1:0] FIN   = 2'd3;

  logic [1:0]  state;
  logic [15:0] length_q;
  logic [15:0] word_count;
  logic [1:0]  byte_count;
  logic        too_long;

  // Handshake: a byte moves on a rising edge where ByteValid && ByteReady; the source
  // holds ByteData stable until then. ByteReady is high only in RECV.
  assign ByteReady = (state == RECV);
  assign WrEn      = (state == WRITE);
  assign Done      = (state == FIN);
  assign Busy      = (state == RECV) || (state == WRITE);
  assign fsm_state = state;
  assign too_long  = ({16'd0, Length} > DEPTH_WORDS);

`ifdef LOADER_CHECKSUM_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      Checksum <= 32'd0;
    end else if (state == IDLE && Start && !too_long) begin
      Checksum <= 32'd0;
    end else if (state == WRITE) begin
      Checksum <= Checksum + WrData;
    end
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      length_q   <= 16'd0;
      word_count <= 16'd0;
      byte_count <= 2'd0;
      WrAddress  <= BASE_ADDR;
      WrData     <= 32'd0;
      Error      <= 1'b0;
    end else begin
      Error <= 1'b0;
      case (state)
        IDLE: begin
          if (Start) begin
            if (too_long) begin
              Error <= 1'b1;
            end else if (Length == 16'd0) begin
              state <= FIN;
            end else begin
              state      <= RECV;
              length_q   <= Length;
              word_count <= 16'd0;
              byte_count <= 2'd0;
              WrAddress  <= BASE_ADDR;
            end
          end
        end
        RECV: begin
          if (ByteValid) begin
            WrData[{byte_count, 3'b000} +: 8] <= ByteData;
            byte_count <= byte_count + 2'd1;
            if (byte_count == 2'd3) state <= WRITE;
          end
        end
        WRITE: begin
          // Address advances as the write retires so it always equals BASE + 4*count.
          WrAddress  <= WrAddress + 32'd4;
          word_count <= word_count + 16'd1;
          state      <= (word_count + 16'd1 == length_q) ? FIN : RECV;
        end
        FIN: begin
          WrAddress  <= BASE_ADDR;
          word_count <= 16'd0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
